// File: rtl/stdp_train_pkg.sv
// Shared types and default constants for the STDP training supervisor.
package stdp_train_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int TERM_ADDR_DEF = 143;
  localparam int CNT_W_DEF     = 4;

endpackage

// File: rtl/sweep_counter.sv
// One training channel: terminal-address match, rising-edge detect and a saturating sweep counter.
module sweep_counter #(
  parameter int ADR_W     = 8,
  parameter int CNT_W     = 4,
  parameter int TERM_ADDR = 143
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [ADR_W-1:0] addr,
  input  logic             clear,
  input  logic             count_en,
  output logic             hit_edge,
  output logic [CNT_W-1:0] cnt
);

  logic hit;
  logic prev;

  assign hit      = (addr == ADR_W'(TERM_ADDR));
  assign hit_edge = hit & ~prev;

  // prev tracks the match in every state so an address parked at the terminal value never counts twice
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= hit;
      if (clear)
        cnt <= '0;
      else if (count_en && hit_edge && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stdp_train_supervisor.sv
// Early-stop supervisor for the SNN training array: counts ADDR sweeps per channel and drops EN_STDP/EN_Pulse at the limit.
// Optional RUN-state timeout is built when TRAIN_TIMEOUT_EN is defined.
module stdp_train_supervisor
  import stdp_train_pkg::*;
#(
  parameter int CH_NUM      = 6,
  parameter int ADR_W       = 8,
  parameter int TERM_ADDR   = TERM_ADDR_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    BTN,
  input  logic [CH_NUM-1:0]       SEL_CH,
  input  logic                    MODE,
  input  logic [CNT_W-1:0]        LIMIT,
  input  logic [CH_NUM*ADR_W-1:0] ADDR_FLAT,
  output logic                    EN_STDP,
  output logic                    EN_Pulse,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [CH_NUM-1:0]       DONE_CH,
  output logic                    TIMEOUT,
  output logic [CH_NUM*CNT_W-1:0] SWEEP_CNT
);

  localparam int CW1 = CNT_W + 1;

  state_t            state, state_nx;
  logic              btn_q;
  logic              btn_edge;
  logic              start;
  logic              run;
  logic              tmo;
  logic [CH_NUM-1:0] sel_q;
  logic              mode_q;
  logic [CNT_W-1:0]  limit_q;
  logic [CH_NUM-1:0] edge_v;
  logic [CH_NUM-1:0] qual;

  assign btn_edge = BTN & ~btn_q;
  assign run      = (state == RUN);
  assign start    = (state == IDLE) && btn_edge && (MODE || (|SEL_CH));

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    sweep_counter #(
      .ADR_W     (ADR_W),
      .CNT_W     (CNT_W),
      .TERM_ADDR (TERM_ADDR)
    ) u_cnt (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .addr     (ADDR_FLAT[k*ADR_W +: ADR_W]),
      .clear    (start),
      .count_en (run),
      .hit_edge (edge_v[k]),
      .cnt      (SWEEP_CNT[k*CNT_W +: CNT_W])
    );

    // widened by one bit so a saturated counter can never wrap into a false match
    assign qual[k] = run && edge_v[k] && (mode_q || sel_q[k]) &&
                     ((CW1'(SWEEP_CNT[k*CNT_W +: CNT_W]) + CW1'(1)) == CW1'(limit_q));
  end

`ifdef TRAIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] run_cyc;

  always_ff @(posedge CLK) begin
    if (!RST_N)
      run_cyc <= '0;
    else if (start)
      run_cyc <= '0;
    else if (run)
      run_cyc <= run_cyc + 1'b1;
  end

  assign tmo = run && (run_cyc == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if ((|qual) || tmo) state_nx = STOP;
      STOP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // qual takes priority over timeout so a real finish is never reported as a timeout
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      btn_q   <= 1'b0;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      limit_q <= '0;
      DONE_CH <= '0;
      TIMEOUT <= 1'b0;
    end else begin
      btn_q <= BTN;
      if (start) begin
        sel_q   <= SEL_CH;
        mode_q  <= MODE;
        limit_q <= (LIMIT == '0) ? CNT_W'(1) : LIMIT;
        DONE_CH <= '0;
        TIMEOUT <= 1'b0;
      end else if (run) begin
        if (|qual)
          DONE_CH <= qual;
        else if (tmo)
          TIMEOUT <= 1'b1;
      end
    end
  end

  assign EN_STDP  = run;
  assign EN_Pulse = run;
  assign BUSY     = run;
  assign DONE     = (state == STOP);

endmodule

// File: doc/stdp_train_supervisor.md
Name: stdp_train_supervisor

Overview:
Synthesizable replacement for the bench-side early-stop logic around the SNN training array. Watches the ADDR sweep of every training neuron's TX unit and counts completed sweeps, i.e. rising-edge matches of ADDR against a terminal address. Deasserts EN_STDP/EN_Pulse once a programmable sweep limit is reached, on the target channel or on any channel. Sits between the BTN/Neuron training controls and the Training[] generate block of the top level.

Parameters:
CH_NUM, 6, number of training neurons monitored
ADR_W, 8, width of each channel's TX ADDR
TERM_ADDR, 143, ADDR value that marks sweep completion
CNT_W, 4, width of each per-channel sweep counter
TIMEOUT_CYC, 100000, RUN-state cycle limit (only with TRAIN_TIMEOUT_EN)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  reset, synchronous, active-low
BTN  in  1  training start; rising edge detected internally
SEL_CH  in  CH_NUM  one-hot target channel (Neuron bus); latched at start
MODE  in  1  0 = stop on target channel only, 1 = stop on any channel; latched at start
LIMIT  in  CNT_W  sweep count that ends training; latched at start; 0 treated as 1
ADDR_FLAT  in  CH_NUM*ADR_W  channel k ADDR at [k*ADR_W +: ADR_W]
EN_STDP  out  1  STDP enable to training array
EN_Pulse  out  1  pulse-generator enable
BUSY  out  1  high in RUN
DONE  out  1  one-cycle pulse when training ends
DONE_CH  out  CH_NUM  channels whose count hit the limit (held until next start)
TIMEOUT  out  1  training ended by timeout (held until next start)
SWEEP_CNT  out  CH_NUM*CNT_W  live per-channel counters

Behaviour:
- Reset (RST_N low at a clock edge): state IDLE; all outputs 0; counters, prev-match and BTN edge registers cleared.
- hit[k] = (ADDR_k == TERM_ADDR); prev[k] <= hit[k] every cycle in every state; edge[k] = hit[k] & ~prev[k].
- BTN edge = BTN & ~BTN_q; BTN_q registered every cycle.
- IDLE: on BTN edge -> RUN. If MODE=0 and SEL_CH=0, the start is rejected and the block stays IDLE. Same edge: clear counters, DONE_CH and TIMEOUT; latch SEL_CH/MODE/LIMIT; EN_STDP=EN_Pulse=BUSY=1 in the next cycle.
- RUN: cnt[k] <= cnt[k]+1 on edge[k]; counters saturate at 2^CNT_W-1.
  - qual[k] = (cnt[k]+1 == LIMIT_eff) & edge[k] & (MODE | SEL_q[k]).
  - Any qual -> STOP at the same edge; EN_STDP, EN_Pulse and BUSY are low from the next cycle.
  - DONE_CH latches all qual bits together, so simultaneous hits set multiple bits.
  - Latency: a match in cycle t drops EN in cycle t+1.
  - Non-qualifying channels keep counting; BTN edges are ignored.
- Counters do not change outside RUN. A channel already at TERM_ADDR at start does not count until it leaves and returns.
- STOP: DONE=1 for exactly one cycle, then -> IDLE. A BTN edge during STOP is ignored.
- Reset mid-RUN: immediate return to IDLE with all outputs 0; no DONE pulse.

Optional Feature:
TRAIN_TIMEOUT_EN
- Defined: a RUN cycle counter of width clog2(TIMEOUT_CYC+1) clears on entry to RUN. When it reaches TIMEOUT_CYC with no qual, the block goes to STOP with TIMEOUT=1 and DONE_CH=0. If qual and timeout occur in the same cycle, qual wins and TIMEOUT=0.
- Undefined: no counter is built; TIMEOUT is tied 0.

Decomposition:
- Package stdp_train_pkg: state enum (IDLE, RUN, STOP) and default TERM_ADDR/CNT_W constants, shared with the top level.
- One sub-module, sweep_counter: per-channel prev-match register, edge detect and saturating counter, instantiated CH_NUM times in a generate loop. The FSM stays in the parent.

Test Plan:
1. Reset mid-RUN -> all outputs 0 next cycle; no DONE.
2. MODE=0, SEL_CH=6'b000001, LIMIT=2; ch0 ADDR sweeps 0..143 twice -> EN_STDP low one cycle after the 2nd hit of 143; DONE pulse; DONE_CH=000001; SWEEP_CNT ch0=2.
3. MODE=0, SEL_CH=ch2, LIMIT=2; ch4 hits 143 three times -> EN stays high, ch4 count=3; then ch2 hits twice -> stop, DONE_CH=000100.
4. MODE=1, LIMIT=1; ch1 and ch5 hit 143 in the same cycle -> DONE_CH=100010, single DONE pulse.
5. ch3 ADDR held at 143 across the start edge, LIMIT=1 -> no count until ADDR leaves and returns; ADDR held at 143 for 5 cycles counts once; LIMIT=0 behaves as 1.
6. With TRAIN_TIMEOUT_EN and TIMEOUT_CYC=50, no hits -> EN low after 50 RUN cycles; TIMEOUT=1, DONE_CH=0. Without the macro -> EN stays high, TIMEOUT=0.
